// File: rtl/rv32_lsu_bus_bridge.sv
// rtl/rv32_lsu_bus_bridge.sv - RV32 load/store unit bridging the core data port to a valid/ready bus
module rv32_lsu_bus_bridge #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] i_core_addr,
    input  logic          i_core_read,
    input  logic          i_core_write,
    input  logic [2:0]    i_core_funct3,
    input  logic [31:0]   i_core_wdata,
    output logic [31:0]   o_core_rdata,
    output logic          o_stall,
    output logic          o_done,
    output logic          o_access_err,
    output logic          o_bus_req_valid,
    input  logic          i_bus_req_ready,
    output logic [AW-1:0] o_bus_addr,
    output logic          o_bus_we,
    output logic [3:0]    o_bus_wstrb,
    output logic [31:0]   o_bus_wdata,
    input  logic          i_bus_rsp_valid,
    input  logic [31:0]   i_bus_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_addr;
    logic            r_we;
    logic [3:0]      r_wstrb;
    logic [31:0]     r_wdata;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic            w_req;
    logic            w_bad;
    logic            w_timeout;
    logic [3:0]      w_strb;
    logic [31:0]     w_wdata;
    logic [15:0]     w_lane;
    logic [31:0]     w_fmt;

    assign w_req     = i_core_read | i_core_write;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_bad = 1'b0;
        if (i_core_read && i_core_write)                                 w_bad = 1'b1;
        if (i_core_funct3 == 3'd3 || i_core_funct3 == 3'd6 || i_core_funct3 == 3'd7) w_bad = 1'b1;
        if (i_core_write && i_core_funct3 > 3'd2)                        w_bad = 1'b1;
        if (i_core_funct3[1:0] == 2'd1 && i_core_addr[0])                w_bad = 1'b1;
        if (i_core_funct3 == 3'd2 && i_core_addr[1:0] != 2'b00)          w_bad = 1'b1;
    end

    // Stores replicate the datum across every lane so the strobes alone select the bytes.
    always_comb begin
        w_strb  = 4'b0000;
        w_wdata = 32'h0;
        if (i_core_write) begin
            case (i_core_funct3[1:0])
                2'd0: begin
                    w_strb  = 4'b0001 << i_core_addr[1:0];
                    w_wdata = {4{i_core_wdata[7:0]}};
                end
                2'd1: begin
                    w_strb  = 4'b0011 << {i_core_addr[1], 1'b0};
                    w_wdata = {2{i_core_wdata[15:0]}};
                end
                default: begin
                    w_strb  = 4'b1111;
                    w_wdata = i_core_wdata;
                end
            endcase
        end
    end

    assign w_lane = 16'(i_bus_rdata >> {r_off, 3'b000});

    always_comb begin
        w_fmt = i_bus_rdata;
        case (r_funct3)
            3'd0:    w_fmt = {{24{w_lane[7]}}, w_lane[7:0]};
            3'd1:    w_fmt = {{16{w_lane[15]}}, w_lane};
            3'd4:    w_fmt = {24'h0, w_lane[7:0]};
            3'd5:    w_fmt = {16'h0, w_lane};
            default: w_fmt = i_bus_rdata;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_req) w_next = w_bad ? S_DONE : S_REQ;
            S_REQ:  if (i_bus_req_ready) w_next = S_WAIT;
            S_WAIT: if (i_bus_rsp_valid || w_timeout) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wstrb  <= 4'b0000;
            r_wdata  <= 32'h0;
            r_funct3 <= 3'd0;
            r_off    <= 2'd0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_req) begin
                    r_addr   <= {i_core_addr[AW-1:2], 2'b00};
                    r_we     <= i_core_write;
                    r_wstrb  <= w_strb;
                    r_wdata  <= w_wdata;
                    r_funct3 <= i_core_funct3;
                    r_off    <= i_core_addr[1:0];
                    r_err    <= w_bad;
                    r_rdata  <= 32'h0;
                end
                S_REQ: r_cnt <= '0;
                S_WAIT: begin
                    if (i_bus_rsp_valid)  r_rdata <= r_we ? 32'h0 : w_fmt;
                    else if (w_timeout)   r_err   <= 1'b1;
                    else                  r_cnt   <= r_cnt + 1'b1;
                end
                default: begin
                    r_rdata <= 32'h0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign o_stall         = w_req && (r_state != S_DONE);
    assign o_done          = (r_state == S_DONE);
    assign o_access_err    = r_err;
    assign o_core_rdata    = r_rdata;
    assign o_bus_req_valid = (r_state == S_REQ);
    assign o_bus_addr      = r_addr;
    assign o_bus_we        = r_we;
    assign o_bus_wstrb     = r_wstrb;
    assign o_bus_wdata     = r_wdata;
endmodule

// File: tb/tb_rv32_lsu_bus_bridge.sv
// tb/tb_rv32_lsu_bus_bridge.sv - directed self-checking bench for rv32_lsu_bus_bridge
module tb_rv32_lsu_bus_bridge;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] core_addr = 32'h0;
    logic        core_read = 1'b0;
    logic        core_write = 1'b0;
    logic [2:0]  core_funct3 = 3'd0;
    logic [31:0] core_wdata = 32'h0;
    logic [31:0] core_rdata;
    logic        stall, done, access_err, bus_req_valid, bus_we;
    logic        bus_req_ready = 1'b0;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rsp_valid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int passed = 0;
    int total = 0;

    int          obs_stalls;
    logic        obs_done, obs_err, obs_req, obs_we;
    logic [31:0] obs_rdata, obs_addr, obs_wdata;
    logic [3:0]  obs_wstrb;

    rv32_lsu_bus_bridge #(.AW(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_core_addr(core_addr), .i_core_read(core_read), .i_core_write(core_write),
        .i_core_funct3(core_funct3), .i_core_wdata(core_wdata),
        .o_core_rdata(core_rdata), .o_stall(stall), .o_done(done), .o_access_err(access_err),
        .o_bus_req_valid(bus_req_valid), .i_bus_req_ready(bus_req_ready),
        .o_bus_addr(bus_addr), .o_bus_we(bus_we), .o_bus_wstrb(bus_wstrb), .o_bus_wdata(bus_wdata),
        .i_bus_rsp_valid(bus_rsp_valid), .i_bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Stimulus driver: ready and rsp held high, observations collected for the caller to check.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rsp_data);
        @(posedge clk); #1;
        core_read = rd; core_write = wr; core_funct3 = f3; core_addr = addr; core_wdata = wd;
        bus_req_ready = 1'b1; bus_rsp_valid = 1'b1; bus_rdata = rsp_data;
        obs_stalls = 0; obs_done = 1'b0; obs_err = 1'b0; obs_req = 1'b0; obs_rdata = 32'hx;
        obs_addr = 32'h0; obs_we = 1'b0; obs_wstrb = 4'h0; obs_wdata = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                obs_done = 1'b1; obs_err = access_err; obs_rdata = core_rdata;
                break;
            end
            if (stall) obs_stalls++;
            if (bus_req_valid) begin
                obs_req = 1'b1; obs_addr = bus_addr; obs_we = bus_we;
                obs_wstrb = bus_wstrb; obs_wdata = bus_wdata;
            end
        end
        @(posedge clk); #1;
        core_read = 1'b0; core_write = 1'b0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++; if ({stall, done, access_err, bus_req_valid} !== 4'b0000) $display("FAIL reset_ctrl got %b want 0000", {stall, done, access_err, bus_req_valid}); else passed++;
        total++; if (core_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", core_rdata); else passed++;
        total++; if ({bus_addr, bus_wstrb, bus_we} !== 37'h0) $display("FAIL reset_bus got %h/%b/%b want 0", bus_addr, bus_wstrb, bus_we); else passed++;
        reset_n = 1'b1;
    endtask

    task automatic test_lw;
        run_access(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF);
        total++; if (obs_done !== 1'b1) $display("FAIL lw_done got %b want 1", obs_done); else passed++;
        total++; if (obs_stalls !== 3) $display("FAIL lw_stalls got %0d want 3", obs_stalls); else passed++;
        total++; if (obs_addr !== 32'h100 || obs_we !== 1'b0 || obs_wstrb !== 4'b0000) $display("FAIL lw_bus got %h/%b/%b want 00000100/0/0000", obs_addr, obs_we, obs_wstrb); else passed++;
        total++; if (obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) $display("FAIL lw_rdata got %h/%b want deadbeef/0", obs_rdata, obs_err); else passed++;
        @(negedge clk);
        total++; if (core_rdata !== 32'h0 || done !== 1'b0) $display("FAIL lw_clear got %h/%b want 0/0", core_rdata, done); else passed++;
    endtask

    task automatic test_load_ext;
        run_access(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80112233);
        total++; if (obs_rdata !== 32'hFFFFFF80) $display("FAIL lb got %h want ffffff80", obs_rdata); else passed++;
        total++; if (obs_addr !== 32'h100) $display("FAIL lb_addr got %h want 00000100", obs_addr); else passed++;
        run_access(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80112233);
        total++; if (obs_rdata !== 32'h00000080) $display("FAIL lbu got %h want 00000080", obs_rdata); else passed++;
        run_access(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 32'h80112233);
        total++; if (obs_rdata !== 32'h00008011) $display("FAIL lhu got %h want 00008011", obs_rdata); else passed++;
        run_access(1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 32'h80112233);
        total++; if (obs_rdata !== 32'hFFFF8011) $display("FAIL lh got %h want ffff8011", obs_rdata); else passed++;
        run_access(1'b1, 1'b0, 3'd4, 32'h101, 32'h0, 32'h80112233);
        total++; if (obs_rdata !== 32'h00000022) $display("FAIL lbu1 got %h want 00000022", obs_rdata); else passed++;
    endtask

    task automatic test_store;
        run_access(1'b0, 1'b1, 3'd0, 32'h201, 32'h000000A5, 32'h12345678);
        total++; if (obs_wstrb !== 4'b0010 || obs_wdata !== 32'hA5A5A5A5) $display("FAIL sb got %b/%h want 0010/a5a5a5a5", obs_wstrb, obs_wdata); else passed++;
        total++; if (obs_addr !== 32'h200 || obs_we !== 1'b1) $display("FAIL sb_addr got %h/%b want 00000200/1", obs_addr, obs_we); else passed++;
        total++; if (obs_done !== 1'b1 || obs_rdata !== 32'h0 || obs_err !== 1'b0) $display("FAIL sb_done got %b/%h/%b want 1/0/0", obs_done, obs_rdata, obs_err); else passed++;
        run_access(1'b0, 1'b1, 3'd1, 32'h202, 32'h1234BEEF, 32'h0);
        total++; if (obs_wstrb !== 4'b1100 || obs_wdata !== 32'hBEEFBEEF) $display("FAIL sh got %b/%h want 1100/beefbeef", obs_wstrb, obs_wdata); else passed++;
        run_access(1'b0, 1'b1, 3'd2, 32'h204, 32'hCAFEF00D, 32'h0);
        total++; if (obs_wstrb !== 4'b1111 || obs_wdata !== 32'hCAFEF00D || obs_addr !== 32'h204) $display("FAIL sw got %b/%h/%h want 1111/cafef00d/00000204", obs_wstrb, obs_wdata, obs_addr); else passed++;
    endtask

    task automatic test_errors;
        run_access(1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 32'h55555555);
        total++; if (obs_req !== 1'b0) $display("FAIL lw_mis_req got %b want 0", obs_req); else passed++;
        total++; if (obs_done !== 1'b1 || obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_stalls !== 1) $display("FAIL lw_mis got %b/%b/%h/%0d want 1/1/0/1", obs_done, obs_err, obs_rdata, obs_stalls); else passed++;
        run_access(1'b0, 1'b1, 3'd1, 32'h201, 32'h0, 32'h0);
        total++; if (obs_req !== 1'b0 || obs_err !== 1'b1) $display("FAIL sh_mis got %b/%b want 0/1", obs_req, obs_err); else passed++;
        run_access(1'b1, 1'b0, 3'd3, 32'h100, 32'h0, 32'h0);
        total++; if (obs_req !== 1'b0 || obs_err !== 1'b1) $display("FAIL f3_3 got %b/%b want 0/1", obs_req, obs_err); else passed++;
        run_access(1'b0, 1'b1, 3'd4, 32'h100, 32'h0, 32'h0);
        total++; if (obs_req !== 1'b0 || obs_err !== 1'b1) $display("FAIL sbu got %b/%b want 0/1", obs_req, obs_err); else passed++;
        run_access(1'b1, 1'b1, 3'd2, 32'h100, 32'h0, 32'h0);
        total++; if (obs_req !== 1'b0 || obs_err !== 1'b1) $display("FAIL rdwr got %b/%b want 0/1", obs_req, obs_err); else passed++;
        run_access(1'b1, 1'b0, 3'd2, 32'h108, 32'h0, 32'h01020304);
        total++; if (obs_err !== 1'b0 || obs_rdata !== 32'h01020304) $display("FAIL after_err got %b/%h want 0/01020304", obs_err, obs_rdata); else passed++;
    endtask

    task automatic test_timeout;
        int unstable = 0;
        int waits = 0;
        logic got_done = 1'b0;
        @(posedge clk); #1;
        core_read = 1'b1; core_funct3 = 3'd2; core_addr = 32'h300;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        @(negedge clk);
        total++; if (stall !== 1'b1 || bus_req_valid !== 1'b0) $display("FAIL to_idle got %b/%b want 1/0", stall, bus_req_valid); else passed++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus_req_valid !== 1'b1 || bus_addr !== 32'h300 || bus_we !== 1'b0 || bus_wstrb !== 4'b0000) unstable++;
        end
        total++; if (unstable !== 0) $display("FAIL to_req_stable got %0d bad cycles want 0", unstable); else passed++;
        @(posedge clk); #1 bus_req_ready = 1'b1;
        @(posedge clk); #1 bus_req_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                total++; if (access_err !== 1'b1 || core_rdata !== 32'h0) $display("FAIL to_err got %b/%h want 1/0", access_err, core_rdata); else passed++;
                break;
            end
            if (bus_req_valid) unstable++;
            waits++;
        end
        total++; if (got_done !== 1'b1 || waits !== 8) $display("FAIL to_wait got done=%b cycles=%0d want 1/8", got_done, waits); else passed++;
        @(posedge clk); #1 core_read = 1'b0;
    endtask

    task automatic test_reset_mid;
        int spurious = 0;
        @(posedge clk); #1;
        core_read = 1'b1; core_funct3 = 3'd2; core_addr = 32'h400;
        bus_req_ready = 1'b1; bus_rsp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        core_read = 1'b0;
        #1;
        total++; if (bus_req_valid !== 1'b0 || done !== 1'b0 || stall !== 1'b0) $display("FAIL rst_mid got %b/%b/%b want 0/0/0", bus_req_valid, done, stall); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        bus_rsp_valid = 1'b1; bus_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || bus_req_valid || access_err || core_rdata != 32'h0) spurious++;
        end
        total++; if (spurious !== 0) $display("FAIL rst_stray_rsp got %0d bad cycles want 0", spurious); else passed++;
        bus_rsp_valid = 1'b0;
        run_access(1'b1, 1'b0, 3'd1, 32'h406, 32'h0, 32'h7FFF0000);
        total++; if (obs_rdata !== 32'h00007FFF || obs_stalls !== 3) $display("FAIL rst_recover got %h/%0d want 00007fff/3", obs_rdata, obs_stalls); else passed++;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset;
        test_lw;
        test_load_ext;
        test_store;
        test_errors;
        test_timeout;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
